preadder26_pipe: RTL
====================

Name: preadder26_pipe

Overview:
- Operand-preparation stage ahead of the 26-bit adder in the ADDSUB2 datapath.
- Converts two sign-magnitude operands (sign + 25-bit fraction) into 26-bit two's-complement words.
- Applies the add/sub operation by flipping the effective sign of operand B.
- Two-stage elastic pipeline with valid/ready handshake on both sides. It is the inverse of the post-adder sign/magnitude recovery.

Parameters:
- FRAC_W, 25, fraction magnitude width; data width is FRAC_W+1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept the operand pair.
- sub  input  1  1 = A-B, 0 = A+B.
- sign_a  input  1  sign of A (1 = negative).
- frac_a  input  FRAC_W  magnitude of A.
- sign_b  input  1  sign of B.
- frac_b  input  FRAC_W  magnitude of B.
- out_valid  output  1  converted pair valid.
- out_ready  input  1  downstream adder accepts.
- data_a  output  FRAC_W+1  two's complement of A.
- data_b  output  FRAC_W+1  two's complement of B after sub applied.

Behaviour:
- Reset: while rst_n low, all pipeline registers are cleared asynchronously, so in_ready=1, out_valid=0, data_a=0 and data_b=0.
- Transfer rules:
  - A transfer occurs on a clock edge where valid and ready are both high.
  - in_ready depends only on internal state, never combinationally on in_valid.
- Stage 1 (S1) register:
  - Captures sign_a, frac_a, eff_sign_b = sign_b XOR sub, and frac_b on an input transfer.
  - Sets s1_valid on capture.
- Stage 2 (S2) register:
  - Holds data_a and data_b, computed combinationally from S1 by the conversion rule below.
  - Sets s2_valid on load.
  - Outputs are driven directly from S2.
- Advance conditions:
  - S2 loads when s1_valid && (!s2_valid || out_ready).
  - S1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
- Latency and throughput:
  - 2 cycles from input transfer to out_valid with no backpressure.
  - Sustains 1 pair per cycle while out_ready=1.
- Stall:
  - While out_valid=1 and out_ready=0, data_a, data_b and out_valid are held stable.
  - S1 may fill once; after that in_ready=0.
  - No data is lost or duplicated.
- Simultaneous events:
  - When S2 drains and S1 moves into S2 in the same cycle, S1 may accept new data in that cycle.
- Conversion rule: data = sign ? (~{0,frac} + 1) : {0,frac}, taken mod 2^(FRAC_W+1).
  - The range always fits: -(2^FRAC_W - 1) .. 2^FRAC_W - 1.
  - Negative zero (sign=1, frac=0) yields all-zero.
- Reset mid-operation: in-flight pairs are discarded and the pipeline restarts empty.
- No internal state beyond the two stages and their valid bits.

Optional Feature:
- Macro: PREADDER26_SUM_EN.
- Defined:
  - Adds output sum [FRAC_W+1:0], a sign-extended 27-bit data_a + data_b.
  - sum is registered in S2 alongside data_a and data_b, so it has the same latency and stall behaviour.
  - sum resets to 0.
- Undefined: the sum port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package addsub2_pkg holds:
  - FRAC_W=25 and DATA_W=FRAC_W+1 constants.
  - A typedef for the sign-magnitude operand {sign, frac}.
  - A typedef for the 26-bit two's-complement word.
- One sub-module, sm2tc26:
  - Combinational sign-magnitude to two's-complement converter.
  - Instantiated twice, feeding S2.

Test Plan:
- Reset check: rst_n=0 mid-stream with s1/s2 full. out_valid drops immediately and in_ready=1. After release, first output comes only from newly accepted data.
- Basic conversion, out_ready=1, sub=0:
  - A = (1, 25'h0000001), B = (0, 25'h0000005).
  - Two cycles later: data_a=26'h3FFFFFF, data_b=26'h0000005, out_valid=1.
- Extremes and sub:
  - A = (1, 25'h1FFFFFF) gives data_a=26'h2000001.
  - sub=1 with B = (0, 25'h0000005) gives data_b=26'h3FFFFFB.
  - Negative zero A = (1, 0) gives data_a=26'h0000000.
- Backpressure:
  - Stream 5 pairs back to back with out_ready held 0 from cycle 3.
  - in_ready falls after S1 fills, and outputs stay stable.
  - When out_ready returns to 1, all 5 pairs appear in order with no drops or duplicates.
- Random throughput: random in_valid and out_ready for 10k pairs. Scoreboard matches the conversion rule. With both held high, 1 result per cycle.
- PREADDER26_SUM_EN build: A = (0, 25'h1FFFFFF), B = (0, 25'h1FFFFFF) gives sum=27'h3FFFFFE. A = (1, 3), sub=1, B = (1, 3) gives sum=0.

Source files
------------

// File: rtl/addsub2_pkg.sv
// ============================================================================
// Module      : addsub2_pkg
// Description : Shared constants and operand types for the ADDSUB2 datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub2_pkg;

  localparam int FRAC_W = 25;
  localparam int DATA_W = FRAC_W + 1;

  typedef struct packed {
    logic              sign;
    logic [FRAC_W-1:0] frac;
  } sm_operand_t;

  typedef logic [DATA_W-1:0] tc_word_t;

endpackage : addsub2_pkg

`default_nettype wire

// File: rtl/sm2tc26.sv
// ============================================================================
// Module      : sm2tc26
// Description : Combinational sign-magnitude to two's-complement converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm2tc26
  import addsub2_pkg::*;
#(
  parameter int FRAC_W = addsub2_pkg::FRAC_W
) (
  input  logic              sign_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic [FRAC_W:0]   data_o
);

  localparam int DW = FRAC_W + 1;

  logic [FRAC_W:0] w_mag;

  assign w_mag = {1'b0, frac_i};
  // Negative zero wraps to all-zero through the +1 carry-out.
  assign data_o = sign_i ? (~w_mag + DW'(1)) : w_mag;

endmodule : sm2tc26

`default_nettype wire

// File: rtl/preadder26_pipe.sv
// ============================================================================
// Module      : preadder26_pipe
// Description : Two-stage elastic operand-preparation pipeline ahead of the
//               26-bit adder; optional registered sum via PREADDER26_SUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module preadder26_pipe
  import addsub2_pkg::*;
#(
  parameter int FRAC_W = addsub2_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sub,
  input  logic              sign_a,
  input  logic [FRAC_W-1:0] frac_a,
  input  logic              sign_b,
  input  logic [FRAC_W-1:0] frac_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W:0]   data_a,
  output logic [FRAC_W:0]   data_b
`ifdef PREADDER26_SUM_EN
  ,output logic [FRAC_W+1:0] sum
`endif
);

  logic              s1_valid_q;
  logic              s1_sign_a_q;
  logic [FRAC_W-1:0] s1_frac_a_q;
  logic              s1_sign_b_q;
  logic [FRAC_W-1:0] s1_frac_b_q;

  logic              s2_valid_q;
  logic [FRAC_W:0]   s2_data_a_q;
  logic [FRAC_W:0]   s2_data_b_q;

  logic              w_s1_load;
  logic              w_s2_load;
  logic [FRAC_W:0]   w_data_a_d;
  logic [FRAC_W:0]   w_data_b_d;

  assign w_s2_load = s1_valid_q && (!s2_valid_q || out_ready);
  // Ready looks only at stage state so no combinational path from in_valid.
  assign in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
  assign w_s1_load = in_valid && in_ready;

  sm2tc26 #(.FRAC_W(FRAC_W)) u_conv_a (
    .sign_i (s1_sign_a_q),
    .frac_i (s1_frac_a_q),
    .data_o (w_data_a_d)
  );

  sm2tc26 #(.FRAC_W(FRAC_W)) u_conv_b (
    .sign_i (s1_sign_b_q),
    .frac_i (s1_frac_b_q),
    .data_o (w_data_b_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_a_q <= 1'b0;
      s1_frac_a_q <= '0;
      s1_sign_b_q <= 1'b0;
      s1_frac_b_q <= '0;
    end else begin
      if (w_s1_load) begin
        s1_valid_q  <= 1'b1;
        s1_sign_a_q <= sign_a;
        s1_frac_a_q <= frac_a;
        s1_sign_b_q <= sign_b ^ sub;
        s1_frac_b_q <= frac_b;
      end else if (w_s2_load) begin
        s1_valid_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_data_a_q <= '0;
      s2_data_b_q <= '0;
    end else begin
      if (w_s2_load) begin
        s2_valid_q  <= 1'b1;
        s2_data_a_q <= w_data_a_d;
        s2_data_b_q <= w_data_b_d;
      end else if (out_ready) begin
        s2_valid_q  <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign data_a    = s2_data_a_q;
  assign data_b    = s2_data_b_q;

`ifdef PREADDER26_SUM_EN
  logic [FRAC_W+1:0] s2_sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sum_q <= '0;
    end else if (w_s2_load) begin
      s2_sum_q <= {w_data_a_d[FRAC_W], w_data_a_d} + {w_data_b_d[FRAC_W], w_data_b_d};
    end
  end

  assign sum = s2_sum_q;
`endif

endmodule : preadder26_pipe

`default_nettype wire
